regs_cmd_ctrl: RTL and testbench

Command sequencer that acts as the initiator for the 8×32 register file (`Regs_8_32`). It accepts single commands (WRITE, READ, ADD, CLEAR) over a valid/ready handshake and drives the register file's write port (`WE`/`Addr_W`/`Di`) and both read addresses (`Addr_A`/`Addr_B`). It captures the register file's `QA`/`QB` read data and returns a one-cycle response. It sits between the wall-clock control logic and the register file.

---
 rtl/regs_cmd_ctrl.sv | 145 ++++++++++++++
 tb/tb_regs_cmd_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regs_cmd_ctrl.sv
// Command sequencer driving the 8x32 register file: WRITE, READ, ADD and CLEAR
// commands arrive over valid/ready and finish with a one-cycle rsp_valid pulse.
module regs_cmd_ctrl (
    input  logic        clk,
    input  logic        cr,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [2:0]  cmd_rd,
    input  logic [2:0]  cmd_ra,
    input  logic [2:0]  cmd_rb,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_a,
    output logic [31:0] rsp_b,
    output logic        rsp_carry,
    output logic        rf_we,
    output logic [2:0]  rf_addr_w,
    output logic [31:0] rf_di,
    output logic [2:0]  rf_addr_a,
    output logic [2:0]  rf_addr_b,
    input  logic [31:0] rf_qa,
    input  logic [31:0] rf_qb
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_RD, S_WB, S_CLR, S_RSP
    } state_t;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    state_t      state_q;
    logic [1:0]  op_q;
    logic [2:0]  rd_q, ra_q, rb_q, cnt_q;
    logic [31:0] rsp_a_q, rsp_b_q, rf_di_q;
    logic        rsp_carry_q, add_carry_q, rsp_valid_q, rf_we_q;
    logic [2:0]  rf_addr_w_q;
    logic [32:0] add_sum_d;

    // The sum is formed from the live read data in RD, so the WB write uses the
    // values being captured into rsp_a/rsp_b (old contents when rd aliases ra/rb).
    assign add_sum_d = {1'b0, rf_qa} + {1'b0, rf_qb};

    assign cmd_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_a     = rsp_a_q;
    assign rsp_b     = rsp_b_q;
    assign rsp_carry = rsp_carry_q;
    assign rf_we     = rf_we_q;
    assign rf_addr_w = rf_addr_w_q;
    assign rf_di     = rf_di_q;
    assign rf_addr_a = ra_q;
    assign rf_addr_b = rb_q;

    always_ff @(posedge clk or negedge cr) begin
        if (!cr) begin
            state_q     <= S_IDLE;
            op_q        <= OP_WRITE;
            rd_q        <= '0;
            ra_q        <= '0;
            rb_q        <= '0;
            cnt_q       <= '0;
            rsp_a_q     <= '0;
            rsp_b_q     <= '0;
            rsp_carry_q <= 1'b0;
            add_carry_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rf_we_q     <= 1'b0;
            rf_addr_w_q <= '0;
            rf_di_q     <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q <= cmd_op;
                        rd_q <= cmd_rd;
                        ra_q <= cmd_ra;
                        rb_q <= cmd_rb;
                        case (cmd_op)
                            OP_WRITE: begin
                                rf_we_q     <= 1'b1;
                                rf_addr_w_q <= cmd_rd;
                                rf_di_q     <= cmd_data;
                                state_q     <= S_WR;
                            end
                            OP_READ, OP_ADD: state_q <= S_RD;
                            OP_CLEAR: begin
                                rf_we_q     <= 1'b1;
                                rf_addr_w_q <= '0;
                                rf_di_q     <= '0;
                                cnt_q       <= '0;
                                state_q     <= S_CLR;
                            end
                        endcase
                    end
                end
                S_WR: begin
                    rf_we_q     <= 1'b0;
                    rf_di_q     <= '0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RSP;
                end
                S_RD: begin
                    rsp_a_q <= rf_qa;
                    rsp_b_q <= rf_qb;
                    if (op_q == OP_ADD) begin
                        rf_we_q     <= 1'b1;
                        rf_addr_w_q <= rd_q;
                        rf_di_q     <= add_sum_d[31:0];
                        add_carry_q <= add_sum_d[32];
                        state_q     <= S_WB;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RSP;
                    end
                end
                S_WB: begin
                    rsp_carry_q <= add_carry_q;
                    rf_we_q     <= 1'b0;
                    rf_di_q     <= '0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RSP;
                end
                S_CLR: begin
                    if (cnt_q == 3'd7) begin
                        cnt_q       <= '0;
                        rf_we_q     <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RSP;
                    end else begin
                        cnt_q       <= cnt_q + 3'd1;
                        rf_addr_w_q <= cnt_q + 3'd1;
                    end
                end
                S_RSP:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regs_cmd_ctrl.sv
// Bench for regs_cmd_ctrl: behavioural register file, directed vector table,
// reset-abort and back-to-back sequences, and randomized commands vs a model.
module tb_regs_cmd_ctrl;

    localparam logic [1:0] W = 2'b00, R = 2'b01, A = 2'b10, C = 2'b11;

    logic        clk, cr, cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_rd, cmd_ra, cmd_rb;
    logic [31:0] cmd_data;
    logic        rsp_valid, rsp_carry, rf_we;
    logic [31:0] rsp_a, rsp_b, rf_di, rf_qa, rf_qb;
    logic [2:0]  rf_addr_w, rf_addr_a, rf_addr_b;

    regs_cmd_ctrl dut (
        .clk(clk), .cr(cr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
        .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_a(rsp_a), .rsp_b(rsp_b),
        .rsp_carry(rsp_carry), .rf_we(rf_we), .rf_addr_w(rf_addr_w), .rf_di(rf_di),
        .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b), .rf_qa(rf_qa), .rf_qb(rf_qb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file stand-in: synchronous write, combinational reads, no reset.
    logic [31:0] rf [8];
    logic        rf_init;
    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 8; i++) rf[i] <= 32'h1000_0000 + i;
        end else if (rf_we) begin
            rf[rf_addr_w] <= rf_di;
        end
    end
    assign rf_qa = rf[rf_addr_a];
    assign rf_qb = rf[rf_addr_b];

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: register contents, held response fields, expected writes.
    logic [31:0] mem [8];
    logic [31:0] m_a, m_b;
    logic        m_c;
    logic [2:0]  exp_wa [$];
    logic [31:0] exp_wd [$];

    task automatic model_step(input logic [1:0] op, input logic [2:0] rd, ra, rb,
                              input logic [31:0] data, output logic [31:0] ea, eb,
                              output logic ec, output int lat);
        logic [32:0] s;
        case (op)
            W: begin
                mem[rd] = data;
                exp_wa.push_back(rd); exp_wd.push_back(data);
                lat = 2;
            end
            R: begin
                m_a = mem[ra]; m_b = mem[rb];
                lat = 2;
            end
            A: begin
                m_a = mem[ra]; m_b = mem[rb];
                s = {1'b0, m_a} + {1'b0, m_b};
                m_c = s[32];
                mem[rd] = s[31:0];
                exp_wa.push_back(rd); exp_wd.push_back(s[31:0]);
                lat = 3;
            end
            default: begin
                for (int i = 0; i < 8; i++) begin
                    mem[i] = 32'h0;
                    exp_wa.push_back(3'(i)); exp_wd.push_back(32'h0);
                end
                lat = 9;
            end
        endcase
        ea = m_a; eb = m_b; ec = m_c;
    endtask

    task automatic check_write(input string tag);
        if (exp_wa.size() == 0) begin
            nchk++; nerr++;
            $display("FAIL %s_write: unexpected write addr %0d data %0h", tag, rf_addr_w, rf_di);
        end else begin
            logic [2:0]  wa;
            logic [31:0] wd;
            wa = exp_wa.pop_front();
            wd = exp_wd.pop_front();
            chk({tag, "_write"}, {29'h0, rf_addr_w, rf_di}, {29'h0, wa, wd});
        end
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [2:0] rd, ra, rb,
                           input logic [31:0] data, input logic [31:0] ea, eb,
                           input logic ec, input int elat);
        int  k;
        bit  got;
        @(negedge clk);
        chk({tag, "_ready_idle"}, {63'h0, cmd_ready}, 64'h1);
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_data = data;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_rd = 3'($urandom); cmd_ra = 3'($urandom);
        cmd_rb = 3'($urandom); cmd_data = $urandom;
        k = 0; got = 0;
        while (!got && k < 20) begin
            @(negedge clk);
            k++;
            if (rf_we) check_write(tag);
            else if (rf_di !== 32'h0) chk({tag, "_di_idle"}, {32'h0, rf_di}, 64'h0);
            chk({tag, "_ready_busy"}, {63'h0, cmd_ready}, 64'h0);
            if (rsp_valid) got = 1;
        end
        chk({tag, "_latency"}, 64'(k), 64'(elat));
        chk({tag, "_rsp_a"}, {32'h0, rsp_a}, {32'h0, ea});
        chk({tag, "_rsp_b"}, {32'h0, rsp_b}, {32'h0, eb});
        chk({tag, "_carry"}, {63'h0, rsp_carry}, {63'h0, ec});
        chk({tag, "_writes_left"}, 64'(exp_wa.size()), 64'h0);
        exp_wa.delete(); exp_wd.delete();
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  rd, ra, rb;
        logic [31:0] data, ea, eb;
        logic        ec;
        int          lat;
    } vec_t;

    function automatic vec_t mk(logic [1:0] op, logic [2:0] rd, logic [2:0] ra, logic [2:0] rb,
                                logic [31:0] d, logic [31:0] ea, logic [31:0] eb,
                                logic ec, int lat);
        vec_t v;
        v.op = op; v.rd = rd; v.ra = ra; v.rb = rb; v.data = d;
        v.ea = ea; v.eb = eb; v.ec = ec; v.lat = lat;
        return v;
    endfunction

    vec_t tbl [$];

    initial begin
        logic [31:0] ea, eb, d;
        logic        ec;
        int          lat, nacc, nrsp, cyc;
        logic [31:0] qa [$];
        logic [1:0]  op;

        // Directed table; expectations written by hand from the command rules.
        tbl.push_back(mk(W, 5, 0, 0, 32'hDEADBEEF, 32'h0,        32'h0, 0, 2));
        tbl.push_back(mk(R, 0, 5, 0, 32'h0,        32'hDEADBEEF, 32'h0, 0, 2));
        tbl.push_back(mk(W, 1, 0, 0, 32'hFFFFFFFF, 32'hDEADBEEF, 32'h0, 0, 2));
        tbl.push_back(mk(W, 2, 0, 0, 32'h00000002, 32'hDEADBEEF, 32'h0, 0, 2));
        tbl.push_back(mk(A, 3, 1, 2, 32'h0,        32'hFFFFFFFF, 32'h2, 1, 3));
        tbl.push_back(mk(R, 0, 3, 3, 32'h0,        32'h1,        32'h1, 1, 2));
        tbl.push_back(mk(W, 1, 0, 0, 32'h10,       32'h1,        32'h1, 1, 2));
        tbl.push_back(mk(A, 1, 1, 1, 32'h0,        32'h10,       32'h10, 0, 3));
        tbl.push_back(mk(R, 0, 1, 4, 32'h0,        32'h20, 32'h10000004, 0, 2));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(W, 3'(i), 0, 0, 32'hA0 + i, 32'h20, 32'h10000004, 0, 2));
        tbl.push_back(mk(C, 0, 0, 0, 32'h0,        32'h20, 32'h10000004, 0, 9));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(R, 0, 3'(2 * i), 3'(2 * i + 1), 32'h0, 32'h0, 32'h0, 0, 2));

        cr = 1'b0; rf_init = 1'b1; cmd_valid = 1'b0;
        cmd_op = W; cmd_rd = 0; cmd_ra = 0; cmd_rb = 0; cmd_data = 0;
        for (int i = 0; i < 8; i++) mem[i] = 32'h1000_0000 + i;
        m_a = 0; m_b = 0; m_c = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rf_init = 1'b0;
        chk("rst_ready", {63'h0, cmd_ready}, 64'h1);
        chk("rst_outputs", {rsp_valid, rsp_carry, rf_we, rf_addr_w, rf_addr_a, rf_addr_b, 39'h0},
            64'h0);
        chk("rst_data", {rsp_a, rsp_b | rf_di}, 64'h0);
        cr = 1'b1;

        // Reset in the middle of a CLEAR, after a READ has loaded the response fields.
        model_step(R, 0, 4, 5, 0, ea, eb, ec, lat);
        run_cmd("pre_rd", R, 0, 4, 5, 0, ea, eb, ec, lat);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = C;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_at_cnt3", {60'h0, rf_we, rf_addr_w}, {60'h0, 1'b1, 3'd3});
        cr = 1'b0;
        #1;
        chk("abort_we_async", {63'h0, rf_we}, 64'h0);
        repeat (2) @(negedge clk);
        cr = 1'b1;
        #1;
        chk("abort_ready", {63'h0, cmd_ready}, 64'h1);
        chk("abort_rsp", {rsp_valid, rsp_carry, 62'h0}, 64'h0);
        chk("abort_rsp_ab", {rsp_a, rsp_b}, 64'h0);
        for (int i = 0; i < 3; i++) mem[i] = 32'h0;
        m_a = 0; m_b = 0; m_c = 0;
        for (int i = 0; i < 8; i++) chk("abort_regs", {32'h0, rf[i]}, {32'h0, mem[i]});

        foreach (tbl[i]) begin
            model_step(tbl[i].op, tbl[i].rd, tbl[i].ra, tbl[i].rb, tbl[i].data, ea, eb, ec, lat);
            run_cmd($sformatf("vec%0d", i), tbl[i].op, tbl[i].rd, tbl[i].ra, tbl[i].rb,
                    tbl[i].data, tbl[i].ea, tbl[i].eb, tbl[i].ec, tbl[i].lat);
        end

        // cmd_valid held high across alternating WRITE/READ commands.
        nacc = 0; nrsp = 0; cyc = 0;
        while (nrsp < 6 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (nacc > nrsp) chk("b2b_ready_busy", {63'h0, cmd_ready}, 64'h0);
            if (rf_we) check_write("b2b");
            if (rsp_valid) begin
                if (qa.size() > 0) chk("b2b_rsp_a", {32'h0, rsp_a}, {32'h0, qa.pop_front()});
                nrsp++;
            end
            if (cmd_ready && nacc < 6) begin
                op = (nacc % 2 == 0) ? W : R;
                d  = 32'h600 + nacc;
                cmd_valid = 1'b1; cmd_op = op; cmd_rd = 6; cmd_ra = 6; cmd_rb = 6; cmd_data = d;
                model_step(op, 6, 6, 6, d, ea, eb, ec, lat);
                qa.push_back(ea);
                nacc++;
            end
        end
        cmd_valid = 1'b0;
        chk("b2b_count", {32'(nacc), 32'(nrsp)}, {32'd6, 32'd6});
        repeat (12) begin
            @(negedge clk);
            chk("b2b_no_extra", {62'h0, rsp_valid, rf_we}, 64'h0);
        end
        exp_wa.delete(); exp_wd.delete();

        // Randomized commands against the model.
        for (int n = 0; n < 40; n++) begin
            logic [2:0] rd, ra, rb;
            op = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) op = C;
            rd = 3'($urandom); ra = 3'($urandom); rb = 3'($urandom);
            d  = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom;
            model_step(op, rd, ra, rb, d, ea, eb, ec, lat);
            run_cmd($sformatf("rnd%0d", n), op, rd, ra, rb, d, ea, eb, ec, lat);
        end
        for (int i = 0; i < 8; i++) chk("final_regs", {32'h0, rf[i]}, {32'h0, mem[i]});

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
